ysyx_22050710_axi4full_sram: RTL and testbench



---
 rtl/ysyx_22050710_axi4full_sram_pkg.sv | 17 +
 rtl/ysyx_22050710_axi4full_burst_addr.sv | 31 +++
 rtl/ysyx_22050710_axi4full_sram.sv | 226 ++++++++++++++++++++++
 tb/tb_ysyx_22050710_axi4full_sram.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050710_axi4full_sram_pkg.sv
// Shared encodings for the AXI4-full SRAM slave: burst types, responses, FSM states.
// Pure declarations; no logic, no latency.
package ysyx_22050710_axi4full_sram_pkg;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RD    = 2'd1,
      S_WR    = 2'd2,
      S_WRESP = 2'd3
   } state_e;
endpackage

// File: rtl/ysyx_22050710_axi4full_burst_addr.sv
// Next beat address for FIXED/INCR/WRAP bursts; purely combinational, zero latency.
// Illegal WRAP lengths and the reserved burst encoding fall back to INCR.
module ysyx_22050710_axi4full_burst_addr
   import ysyx_22050710_axi4full_sram_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [7:0]            i_len,
   input  logic [1:0]            i_size,
   input  logic [1:0]            i_burst,
   output logic [ADDR_WIDTH-1:0] o_next
);
   logic [ADDR_WIDTH-1:0] step;
   logic [ADDR_WIDTH-1:0] incr;
   logic [ADDR_WIDTH-1:0] wrap_mask;
   logic                  wrap_legal;

   always_comb begin
      step       = ADDR_WIDTH'(1) << i_size;
      incr       = i_addr + step;
      wrap_mask  = ((ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size) - ADDR_WIDTH'(1);
      wrap_legal = (i_len == 8'd1) || (i_len == 8'd3) || (i_len == 8'd7) || (i_len == 8'd15);
      o_next     = incr;
      if (i_burst == BURST_FIXED) begin
         o_next = i_addr;
      end else if (i_burst == BURST_WRAP && wrap_legal) begin
         o_next = (i_addr & ~wrap_mask) | (incr & wrap_mask);
      end
   end
endmodule

// File: rtl/ysyx_22050710_axi4full_sram.sv
// AXI4-full SRAM slave, one transaction at a time; R data registered (first beat 1 cycle after AR).
// R held stable under ~rready, W accepted every cycle in WR, B held until bready.
module ysyx_22050710_axi4full_sram
   import ysyx_22050710_axi4full_sram_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 4,
   parameter int MEM_WORDS  = 4096
) (
   input  logic                  i_aclk,
   input  logic                  i_arsetn,
   input  logic [ID_WIDTH-1:0]   i_awid,
   input  logic [ADDR_WIDTH-1:0] i_awaddr,
   input  logic [7:0]            i_awlen,
   input  logic [1:0]            i_awsize,
   input  logic [1:0]            i_awburst,
   input  logic [1:0]            i_awlock,
   input  logic [3:0]            i_awcache,
   input  logic [2:0]            i_awprot,
   input  logic                  i_awvalid,
   output logic                  o_awready,
   input  logic [ID_WIDTH-1:0]   i_wid,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [STRB_WIDTH-1:0] i_wstrb,
   input  logic                  i_wlast,
   input  logic                  i_wvalid,
   output logic                  o_wready,
   output logic [ID_WIDTH-1:0]   o_bid,
   output logic [1:0]            o_bresp,
   output logic                  o_bvalid,
   input  logic                  i_bready,
   input  logic [ID_WIDTH-1:0]   i_arid,
   input  logic [ADDR_WIDTH-1:0] i_araddr,
   input  logic [7:0]            i_arlen,
   input  logic [1:0]            i_arsize,
   input  logic [1:0]            i_arburst,
   input  logic [1:0]            i_arlock,
   input  logic [3:0]            i_arcache,
   input  logic [2:0]            i_arprot,
   input  logic                  i_arvalid,
   output logic                  o_arready,
   output logic [ID_WIDTH-1:0]   o_rid,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic [1:0]            o_rresp,
   output logic                  o_rlast,
   output logic                  o_rvalid,
   input  logic                  i_rready
);
   localparam int OFF   = $clog2(STRB_WIDTH);
   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_WORDS * STRB_WIDTH);

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return {1'b0, a} < MEM_BYTES;
   endfunction

   function automatic logic [IDX_W-1:0] widx(input logic [ADDR_WIDTH-1:0] a);
      return a[OFF +: IDX_W];
   endfunction

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   state_e                state_q, state_d;
   logic                  wr_served_q, wr_served_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic [1:0]            size_q, size_d;
   logic [1:0]            burst_q, burst_d;
   logic [8:0]            cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic                  rlast_q, rlast_d;

   logic [ADDR_WIDTH-1:0] addr_next;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_ok;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  grant_rd, grant_wr;
   logic                  mem_we;
   logic                  unused_ok;

   ysyx_22050710_axi4full_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_burst_addr (
      .i_addr  (addr_q),
      .i_len   (len_q),
      .i_size  (size_q),
      .i_burst (burst_q),
      .o_next  (addr_next)
   );

   // The first beat is fetched straight from AR; later beats from the stepped address.
   assign rd_addr = (state_q == S_IDLE) ? i_araddr : addr_next;
   assign rd_ok   = in_range(rd_addr);
   assign rd_word = rd_ok ? mem[widx(rd_addr)] : '0;

   always_comb begin
      state_d     = state_q;
      wr_served_d = wr_served_q;
      id_d        = id_q;
      addr_d      = addr_q;
      len_d       = len_q;
      size_d      = size_q;
      burst_d     = burst_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      rvalid_d    = rvalid_q;
      rdata_d     = rdata_q;
      rresp_d     = rresp_q;
      rlast_d     = rlast_q;
      o_arready   = 1'b0;
      o_awready   = 1'b0;
      o_wready    = 1'b0;
      mem_we      = 1'b0;
      grant_rd    = i_arvalid && (!i_awvalid || wr_served_q);
      grant_wr    = i_awvalid && !grant_rd;
      case (state_q)
         S_IDLE: begin
            o_arready = grant_rd;
            o_awready = grant_wr;
            if (grant_rd) begin
               {id_d, addr_d, len_d, size_d, burst_d} = {i_arid, i_araddr, i_arlen, i_arsize, i_arburst};
               cnt_d       = '0;
               wr_served_d = 1'b0;
               rvalid_d    = 1'b1;
               rdata_d     = rd_word;
               rresp_d     = rd_ok ? RESP_OKAY : RESP_SLVERR;
               rlast_d     = (i_arlen == 8'd0);
               state_d     = S_RD;
            end else if (grant_wr) begin
               {id_d, addr_d, len_d, size_d, burst_d} = {i_awid, i_awaddr, i_awlen, i_awsize, i_awburst};
               cnt_d       = '0;
               err_d       = 1'b0;
               wr_served_d = 1'b1;
               state_d     = S_WR;
            end
         end
         S_RD: begin
            if (i_rready) begin
               if (rlast_q) begin
                  rvalid_d = 1'b0;
                  rlast_d  = 1'b0;
                  state_d  = S_IDLE;
               end else begin
                  cnt_d   = cnt_q + 9'd1;
                  addr_d  = addr_next;
                  rdata_d = rd_word;
                  rresp_d = rd_ok ? RESP_OKAY : RESP_SLVERR;
                  rlast_d = ((cnt_q + 9'd1) == {1'b0, len_q});
               end
            end
         end
         S_WR: begin
            o_wready = 1'b1;
            if (i_wvalid) begin
               // Beats beyond len are dropped; the counter parks at len+1.
               if (cnt_q <= {1'b0, len_q}) begin
                  cnt_d = cnt_q + 9'd1;
                  if (in_range(addr_q)) mem_we = 1'b1;
                  else                  err_d  = 1'b1;
               end
               if (i_wlast != (cnt_q == {1'b0, len_q})) err_d = 1'b1;
               addr_d = addr_next;
               if (i_wlast) state_d = S_WRESP;
            end
         end
         default: begin
            if (i_bready) state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_aclk or negedge i_arsetn) begin
      if (!i_arsetn) begin
         state_q     <= S_IDLE;
         wr_served_q <= 1'b1;
         id_q        <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         rresp_q     <= '0;
         rlast_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_served_q <= wr_served_d;
         id_q        <= id_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         size_q      <= size_d;
         burst_q     <= burst_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         rresp_q     <= rresp_d;
         rlast_q     <= rlast_d;
      end
   end

   always_ff @(posedge i_aclk) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            if (i_wstrb[b]) mem[widx(addr_q)][b*8 +: 8] <= i_wdata[b*8 +: 8];
         end
      end
   end

   assign o_rvalid = rvalid_q;
   assign o_rdata  = rdata_q;
   assign o_rresp  = rresp_q;
   assign o_rlast  = rlast_q;
   assign o_rid    = id_q;
   assign o_bvalid = (state_q == S_WRESP);
   assign o_bresp  = (o_bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
   assign o_bid    = id_q;

   assign unused_ok = ^{i_awlock, i_awcache, i_awprot, i_arlock, i_arcache, i_arprot, i_wid};
endmodule

// File: tb/tb_ysyx_22050710_axi4full_sram.sv
// Directed bench for the AXI4-full SRAM slave: preload writes, table of read bursts,
// then hand sequences for reset, contention, backpressure and write responses.
module tb_ysyx_22050710_axi4full_sram;
   import ysyx_22050710_axi4full_sram_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  awid = '0, arid = '0, wid = '0;
   logic [31:0] awaddr = '0, araddr = '0;
   logic [7:0]  awlen = '0, arlen = '0;
   logic [1:0]  awsize = '0, arsize = '0, awburst = '0, arburst = '0;
   logic        awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
   logic        bready = 1'b0, rready = 1'b0;
   logic [63:0] wdata = '0;
   logic [7:0]  wstrb = '0;
   logic        awready, wready, bvalid, arready, rvalid, rlast;
   logic [3:0]  bid, rid;
   logic [1:0]  bresp, rresp;
   logic [63:0] rdata;

   int errs = 0;
   int checks = 0;

   logic [63:0] wr_data [16];
   logic [7:0]  wr_strb [16];
   logic [63:0] rd_data [16];
   logic [1:0]  rd_resp [16];
   logic        rd_last [16];
   logic [3:0]  rd_id   [16];

   typedef struct packed {
      logic [31:0]      addr;
      logic [7:0]       len;
      logic [1:0]       burst;
      logic [3:0]       id;
      logic [1:0]       resp;
      logic [3:0][63:0] d;
   } rvec_t;

   always #5 clk = ~clk;

   ysyx_22050710_axi4full_sram dut (
      .i_aclk(clk), .i_arsetn(rst_n),
      .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize), .i_awburst(awburst),
      .i_awlock(2'b00), .i_awcache(4'h0), .i_awprot(3'h0), .i_awvalid(awvalid), .o_awready(awready),
      .i_wid(wid), .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready),
      .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
      .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize), .i_arburst(arburst),
      .i_arlock(2'b00), .i_arcache(4'h0), .i_arprot(3'h0), .i_arvalid(arvalid), .o_arready(arready),
      .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid), .i_rready(rready)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ar_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
      int n = 0;
      arid = id; araddr = a; arlen = l; arsize = 2'd3; arburst = b; arvalid = 1'b1;
      #1;
      while (!arready && n < 50) begin tick(); n++; end
      chk("ar_handshake", arready, 1);
      tick();
      arvalid = 1'b0;
   endtask

   task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
      int n = 0;
      awid = id; awaddr = a; awlen = l; awsize = 2'd3; awburst = b; awvalid = 1'b1;
      #1;
      while (!awready && n < 50) begin tick(); n++; end
      chk("aw_handshake", awready, 1);
      tick();
      awvalid = 1'b0;
   endtask

   task automatic w_send(input int nbeats, input int last_at);
      for (int i = 0; i < nbeats; i++) begin
         int n = 0;
         wdata = wr_data[i]; wstrb = wr_strb[i]; wlast = (i == last_at); wvalid = 1'b1;
         #1;
         while (!wready && n < 50) begin tick(); n++; end
         chk("w_handshake", wready, 1);
         tick();
      end
      wvalid = 1'b0; wlast = 1'b0;
      chk("b_one_cycle_after_wlast", bvalid, 1);
   endtask

   task automatic b_recv(input string nm, input logic [3:0] eid, input logic [1:0] eresp);
      int n = 0;
      while (!bvalid && n < 50) begin tick(); n++; end
      chk({nm, "_bvalid"}, bvalid, 1);
      chk({nm, "_bresp"}, bresp, eresp);
      chk({nm, "_bid"}, bid, eid);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk({nm, "_bvalid_drop"}, bvalid, 0);
   endtask

   task automatic r_recv(input int nbeats);
      rready = 1'b1;
      for (int i = 0; i < nbeats; i++) begin
         int n = 0;
         while (!rvalid && n < 50) begin tick(); n++; end
         chk("r_valid", rvalid, 1);
         rd_data[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast; rd_id[i] = rid;
         tick();
      end
      rready = 1'b0;
   endtask

   task automatic write_burst(input string nm, input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                              input logic [1:0] b, input int nbeats, input logic [1:0] eresp);
      aw_send(id, a, l, b);
      w_send(nbeats, nbeats - 1);
      b_recv(nm, id, eresp);
   endtask

   function automatic rvec_t mk(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                                input logic [3:0] id, input logic [1:0] rs,
                                input logic [63:0] d0, input logic [63:0] d1,
                                input logic [63:0] d2, input logic [63:0] d3);
      rvec_t v;
      v.addr = a; v.len = l; v.burst = b; v.id = id; v.resp = rs;
      v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rvec_t vecs [9];
      vecs[0] = mk(32'h100,  8'd3, BURST_INCR,  4'd2, RESP_OKAY,   64'd1, 64'd2, 64'd3, 64'd4);
      vecs[1] = mk(32'h018,  8'd3, BURST_WRAP,  4'd1, RESP_OKAY,   64'hA3, 64'hA0, 64'hA1, 64'hA2);
      vecs[2] = mk(32'h200,  8'd0, BURST_INCR,  4'd0, RESP_OKAY,   64'h22222222_11111111, 0, 0, 0);
      vecs[3] = mk(32'h040,  8'd1, BURST_FIXED, 4'd1, RESP_OKAY,   64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D, 0, 0);
      vecs[4] = mk(32'h8000, 8'd0, BURST_INCR,  4'd3, RESP_SLVERR, 64'd0, 0, 0, 0);
      vecs[5] = mk(32'h300,  8'd1, BURST_INCR,  4'd0, RESP_OKAY,   64'h55, 64'h66, 0, 0);
      vecs[6] = mk(32'h108,  8'd1, 2'b11,       4'd2, RESP_OKAY,   64'd2, 64'd3, 0, 0);
      vecs[7] = mk(32'h108,  8'd2, BURST_WRAP,  4'd1, RESP_OKAY,   64'd2, 64'd3, 64'd4, 0);
      vecs[8] = mk(32'h108,  8'd1, BURST_WRAP,  4'd3, RESP_OKAY,   64'd2, 64'd1, 0, 0);

      // Reset state
      #3;
      chk("rst_r_outputs", {rvalid, rlast, rresp, rid, rdata}, 0);
      chk("rst_b_w_outputs", {bvalid, bresp, bid, wready, awready, arready}, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Preload and write-path checks
      wr_data[0] = 64'hDEADBEEF_CAFEF00D; wr_strb[0] = 8'hFF;
      write_burst("wr_0x40", 4'd0, 32'h40, 8'd0, BURST_INCR, 1, RESP_OKAY);
      for (int i = 0; i < 4; i++) begin wr_data[i] = 64'hA0 + 64'(i); wr_strb[i] = 8'hFF; end
      write_burst("wr_0x00", 4'd1, 32'h0, 8'd3, BURST_INCR, 4, RESP_OKAY);
      for (int i = 0; i < 4; i++) begin wr_data[i] = 64'(i + 1); wr_strb[i] = 8'hFF; end
      write_burst("wr_incr_0x100", 4'd3, 32'h100, 8'd3, BURST_INCR, 4, RESP_OKAY);
      wr_data[0] = 64'h11111111_11111111; wr_strb[0] = 8'h0F;
      wr_data[1] = 64'h22222222_22222222; wr_strb[1] = 8'hF0;
      write_burst("wr_fixed_strb", 4'd2, 32'h200, 8'd1, BURST_FIXED, 2, RESP_OKAY);
      wr_data[0] = 64'h55; wr_data[1] = 64'h66; wr_strb[0] = 8'hFF; wr_strb[1] = 8'hFF;
      write_burst("wr_early_wlast", 4'd1, 32'h300, 8'd3, BURST_INCR, 2, RESP_SLVERR);
      wr_data[0] = 64'h99;
      write_burst("wr_out_of_range", 4'd2, 32'h8000, 8'd0, BURST_INCR, 1, RESP_SLVERR);

      // Single read: first beat exactly one cycle after the AR handshake
      ar_send(4'd1, 32'h40, 8'd0, BURST_INCR);
      chk("single_rvalid_n1", rvalid, 1);
      chk("single_rdata", rdata, 64'hDEADBEEF_CAFEF00D);
      chk("single_rlast", rlast, 1);
      chk("single_rid", rid, 1);
      chk("single_rresp", rresp, RESP_OKAY);
      r_recv(1);

      // Table of read bursts
      for (int v = 0; v < 9; v++) begin
         ar_send(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].burst);
         r_recv(int'(vecs[v].len) + 1);
         for (int i = 0; i <= int'(vecs[v].len); i++) begin
            chk($sformatf("v%0d_b%0d_data", v, i), rd_data[i], vecs[v].d[i]);
            chk($sformatf("v%0d_b%0d_resp", v, i), rd_resp[i], vecs[v].resp);
            chk($sformatf("v%0d_b%0d_last", v, i), rd_last[i], (i == int'(vecs[v].len)));
            chk($sformatf("v%0d_b%0d_id", v, i), rd_id[i], vecs[v].id);
         end
      end

      // Reset in the middle of a read burst
      ar_send(4'd2, 32'h100, 8'd3, BURST_INCR);
      chk("mid_rvalid_before_rst", rvalid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_r_outputs", {rvalid, rlast, rresp, rid, rdata}, 0);
      chk("mid_rst_b_w_outputs", {bvalid, bresp, bid, wready, awready, arready}, 0);
      tick();
      chk("mid_rst_rvalid_held", rvalid, 0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_no_beat", rvalid, 0);

      // Contention after reset: read wins the first tie
      arid = 4'd1; araddr = 32'h100; arlen = 8'd3; arsize = 2'd3; arburst = BURST_INCR; arvalid = 1'b1;
      awid = 4'd2; awaddr = 32'h400; awlen = 8'd0; awsize = 2'd3; awburst = BURST_INCR; awvalid = 1'b1;
      #1;
      chk("tie1_arready", arready, 1);
      chk("tie1_awready", awready, 0);
      tick();
      arvalid = 1'b0;
      chk("tie1_rvalid_n1", rvalid, 1);
      chk("tie1_rdata0", rdata, 64'd1);
      chk("rd_blocks_aw", awready, 0);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("stall%0d_rdata", c), rdata, 64'd2);
         chk($sformatf("stall%0d_rvalid", c), rvalid, 1);
         chk($sformatf("stall%0d_rlast", c), rlast, 0);
      end
      r_recv(3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("bp_b%0d_data", i), rd_data[i], 64'(i + 2));
         chk($sformatf("bp_b%0d_last", i), rd_last[i], (i == 2));
      end

      // Second tie: write wins because the read was served last
      arid = 4'd1; araddr = 32'h400; arlen = 8'd0; arvalid = 1'b1;
      #1;
      chk("tie2_awready", awready, 1);
      chk("tie2_arready", arready, 0);
      tick();
      awvalid = 1'b0;
      arvalid = 1'b0;
      wr_data[0] = 64'h77; wr_strb[0] = 8'hFF;
      w_send(1, 0);
      b_recv("tie2_b", 4'd2, RESP_OKAY);
      ar_send(4'd1, 32'h400, 8'd0, BURST_INCR);
      r_recv(1);
      chk("readback_after_tie", rd_data[0], 64'h77);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
